// File: rtl/aes_stream_frontend.sv
// Word-serial front/back end wrapped around a combinational AES-256 core.
// Optional build macro AES_FRONTEND_CLEAR_EN wipes plaintext/output data after each frame.
module aes_stream_frontend #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         reset_n_i,
    input  logic         in_v_i,
    input  logic [31:0]  in_data_i,
    input  logic         load_key_i,
    output logic         in_ready_o,
    output logic         out_v_o,
    output logic [31:0]  out_data_o,
    input  logic         out_yumi_i,
    output logic [127:0] core_plaintext_o,
    output logic [255:0] core_key_o,
    input  logic [127:0] core_ciphertext_i,
    output logic         busy_o,
    output logic         key_valid_o
);

    // Handshakes: an input word moves on a clock edge where in_v_i & in_ready_o;
    // an output word is consumed on an edge where out_yumi_i & out_v_o.

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_KEY = 3'd1;
    localparam logic [2:0] ST_LOAD_PT  = 3'd2;
    localparam logic [2:0] ST_SETTLE   = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    // The counter spans the settle window plus the capture edge, so out_v_o
    // rises SETTLE_CYCLES+1 edges after the last plaintext handshake.
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES);

    logic [2:0]    state_q;
    logic [2:0]    word_cnt_q;
    logic [SW-1:0] settle_cnt_q;
    logic [255:0]  key_q;
    logic [127:0]  pt_q;
    logic [127:0]  out_q;
    logic          out_v_q;
    logic          key_valid_q;
    logic          in_fire;
    logic          out_fire;

    assign in_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOAD_KEY) ||
                        (state_q == ST_LOAD_PT);
    assign in_fire    = in_v_i & in_ready_o;
    assign out_fire   = out_yumi_i & out_v_q;

    assign out_v_o          = out_v_q;
    assign core_plaintext_o = pt_q;
    assign core_key_o       = key_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign key_valid_o      = key_valid_q;

`ifdef AES_FRONTEND_CLEAR_EN
    assign out_data_o = out_v_q ? out_q[127:96] : 32'h0;
`else
    assign out_data_o = out_q[127:96];
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= 3'd0;
            settle_cnt_q <= '0;
            key_q        <= '0;
            pt_q         <= '0;
            out_q        <= '0;
            out_v_q      <= 1'b0;
            key_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        word_cnt_q <= 3'd1;
                        // Without a complete key the frame must start with one.
                        if (load_key_i || !key_valid_q) begin
                            key_q[255:224] <= in_data_i;
                            key_valid_q    <= 1'b0;
                            state_q        <= ST_LOAD_KEY;
                        end else begin
                            pt_q[127:96] <= in_data_i;
                            state_q      <= ST_LOAD_PT;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (in_fire) begin
                        for (int i = 1; i < 8; i++) begin
                            if (word_cnt_q == 3'(i)) key_q[255-32*i -: 32] <= in_data_i;
                        end
                        if (word_cnt_q == 3'd7) begin
                            key_valid_q <= 1'b1;
                            word_cnt_q  <= 3'd0;
                            state_q     <= ST_LOAD_PT;
                        end else begin
                            word_cnt_q <= word_cnt_q + 3'd1;
                        end
                    end
                end
                ST_LOAD_PT: begin
                    if (in_fire) begin
                        for (int i = 0; i < 4; i++) begin
                            if (word_cnt_q == 3'(i)) pt_q[127-32*i -: 32] <= in_data_i;
                        end
                        if (word_cnt_q == 3'd3) begin
                            word_cnt_q   <= 3'd0;
                            settle_cnt_q <= SETTLE_LOAD;
                            state_q      <= ST_SETTLE;
                        end else begin
                            word_cnt_q <= word_cnt_q + 3'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        out_q      <= core_ciphertext_i;
                        out_v_q    <= 1'b1;
                        word_cnt_q <= 3'd0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        out_q <= {out_q[95:0], 32'h0};
                        if (word_cnt_q == 3'd3) begin
                            out_v_q    <= 1'b0;
                            word_cnt_q <= 3'd0;
                            state_q    <= ST_IDLE;
`ifdef AES_FRONTEND_CLEAR_EN
                            pt_q  <= '0;
                            out_q <= '0;
`endif
                        end else begin
                            word_cnt_q <= word_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
